// File: rtl/multi_cycle_mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct encodings,
// FSM states, ALU operations and small decode/ALU helpers.
package multi_cycle_mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Everything that is not an R-type arithmetic op uses the adder (addi, address calc).
  function automatic alu_op_t alu_op_of(input logic [5:0] op, input logic [5:0] fn);
    alu_op_t sel;
    sel = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  sel = ALU_SUB;
        FN_AND:  sel = ALU_AND;
        FN_OR:   sel = ALU_OR;
        FN_SLT:  sel = ALU_SLT;
        default: sel = ALU_ADD;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] alu(input alu_op_t sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    case (sel)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port,
// register 0 hard-wired to zero, synchronous active-low clear of every entry.
module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2,
  input  logic        i_wen,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  assign r_regs[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_regs[gi] <= '0;
      end else if (i_wen && (i_waddr == 5'(gi))) begin
        r_regs[gi] <= i_wdata;
      end
    end
  end

  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with handshaked
// instruction and data ports. Optional perf counters: MULTI_CYCLE_MIPS_PERF_EN.
module multi_cycle_mips
  import multi_cycle_mips_pkg::*;
#(
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ready,
  output logic               rf_wen,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               retire,
`ifdef MULTI_CYCLE_MIPS_PERF_EN
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_retired,
`endif
  output logic               illegal
);

  state_t      r_state, w_state_next;
  logic        r_en;
  logic        r_illegal;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_pc4, r_result;

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_rs_data, w_rt_data;
  logic        w_is_r, w_is_jr, w_is_jump, w_is_mem, w_is_sw, w_is_ctl, w_taken;
  logic [31:0] w_alu_res, w_next_pc;
  logic        w_rf_wen;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  assign w_op = r_ir[31:26];
  assign w_fn = r_ir[5:0];
  assign w_rs = r_ir[25:21];
  assign w_rt = r_ir[20:16];
  assign w_rd = r_ir[15:11];

  assign w_is_jr   = (w_op == OP_RTYPE) && (w_fn == FN_JR);
  assign w_is_r    = (w_op == OP_RTYPE) && !w_is_jr;
  assign w_is_jump = (w_op == OP_J) || (w_op == OP_JAL);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_mem  = (w_op == OP_LW) || w_is_sw;
  assign w_is_ctl  = w_is_jr || w_is_jump || (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_taken   = ((w_op == OP_BEQ) && (r_a == r_b)) || ((w_op == OP_BNE) && (r_a != r_b));

  assign w_alu_res = alu(alu_op_of(w_op, w_fn), r_a, w_is_r ? r_b : r_imm);

  always_comb begin
    w_next_pc = r_pc4;
    if (w_is_jr) begin
      w_next_pc = r_a;
    end else if (w_is_jump) begin
      w_next_pc = {r_pc4[31:28], r_ir[25:0], 2'b00};
    end else if (w_taken) begin
      w_next_pc = r_pc4 + {r_imm[29:0], 2'b00};
    end
  end

  mips_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (w_rs),
    .o_rdata1 (w_rs_data),
    .i_raddr2 (w_rt),
    .o_rdata2 (w_rt_data),
    .i_wen    (w_rf_wen),
    .i_waddr  (w_rf_waddr),
    .i_wdata  (w_rf_wdata)
  );

  // r_en holds requests off for one cycle after any reset edge so an aborted
  // transaction is visibly dropped before fetching restarts.
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    retire       = 1'b0;
    w_rf_wen     = 1'b0;
    w_rf_waddr   = w_is_r ? w_rd : w_rt;
    w_rf_wdata   = r_result;
    case (r_state)
      S_FETCH: begin
        imem_req = r_en;
        if (r_en && imem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_state_next = is_legal(w_op, w_fn) ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (w_is_ctl) begin
          retire       = 1'b1;
          w_state_next = S_FETCH;
          if (w_op == OP_JAL) begin
            w_rf_wen   = 1'b1;
            w_rf_waddr = 5'd31;
            w_rf_wdata = r_pc4;
          end
        end else if (w_is_mem) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_sw;
        if (dmem_ready) begin
          if (w_is_sw) begin
            retire       = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_wen     = 1'b1;
        retire       = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_en      <= 1'b0;
      r_pc      <= PC_RESET;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_en    <= 1'b1;
      if ((r_state == S_DECODE) && !is_legal(w_op, w_fn)) r_illegal <= 1'b1;
      if ((r_state == S_EXEC) && w_is_ctl) r_pc <= w_next_pc;
      if (r_state == S_WB) r_pc <= r_pc4;
      if ((r_state == S_MEM) && dmem_ready && w_is_sw) r_pc <= r_pc4;
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_FETCH: begin
        if (r_en && imem_ready) r_ir <= imem_rdata;
      end
      S_DECODE: begin
        r_a   <= w_rs_data;
        r_b   <= w_rt_data;
        r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
        r_pc4 <= r_pc + 32'd4;
      end
      S_EXEC: begin
        if (!w_is_ctl) r_result <= w_alu_res;
      end
      S_MEM: begin
        if (dmem_ready && !w_is_sw) r_result <= dmem_rdata;
      end
      default: begin
      end
    endcase
  end

  assign imem_addr  = r_pc;
  assign dmem_addr  = r_result[DMEM_AW+1:2];
  assign dmem_wdata = r_b;
  assign rf_wen     = w_rf_wen;
  assign rf_waddr   = w_rf_waddr;
  assign rf_wdata   = w_rf_wdata;
  assign illegal    = r_illegal;

`ifdef MULTI_CYCLE_MIPS_PERF_EN
  logic [31:0] r_perf_cycles, r_perf_retired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cycles  <= '0;
      r_perf_retired <= '0;
    end else begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if (retire) r_perf_retired <= r_perf_retired + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_retired = r_perf_retired;
`endif

endmodule
